// File: rtl/sine_pkg.sv
// Shared types and constants for the sine-wave DAC sequencer.
// Holds the sequencer state encoding, the mid-scale reset code, the minimum
// prescaler divisor and helpers that decode the quarter-wave quadrant.
package sine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // DAC code for 0 V swing (offset-binary mid-scale)
    localparam int MIDSCALE = 512;

    // Smallest divisor that lets one fetch finish before the next tick
    localparam int DIV_MIN = 3;

    // Quadrant codes taken from the top two bits of the table index
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    // Odd quadrants walk the quarter table backwards
    function automatic logic quad_mirrors(input logic [1:0] q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    // Second half of the period produces codes below mid-scale
    function automatic logic quad_negative(input logic [1:0] q);
        return !((q == QUAD_0) || (q == QUAD_1));
    endfunction

endpackage

// File: rtl/sine_prescaler.sv
// Sample-rate prescaler: counts clocks while enabled and emits a one-cycle
// tick every div clocks. A configuration accept loads a new divisor (clamped
// to DIV_MIN so a fetch always completes between ticks) and restarts the count.
module sine_prescaler
    import sine_pkg::*;
#(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(12)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             accept_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_clamped;

    assign div_clamped = (cfg_div_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div_i;
    assign tick_o      = en_i && (cnt_q == (div_q - DIV_W'(1)));

    // Next count and divisor: accept restarts, tick wraps, enable advances
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (accept_i) begin
            div_d = div_clamped;
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter and divisor registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= DIV_RST;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/sine_sequencer.sv
// Sine-wave sequencer for the 10-bit R-2R DAC. On each prescaler tick the
// phase accumulator is sampled into a quarter-table address (mirrored in odd
// quadrants), the external ROM answers one cycle later, and the magnitude is
// unfolded into an offset-binary sample with a one-cycle valid strobe.
module sine_sequencer
    import sine_pkg::*;
#(
    parameter int                 PHASE_W  = 16,
    parameter int                 ADDR_W   = 7,
    parameter int                 MAG_W    = 9,
    parameter int                 OUT_W    = 10,
    parameter int                 DIV_W    = 16,
    parameter logic [PHASE_W-1:0] TUNE_RST = 16'h0080,
    parameter logic [DIV_W-1:0]   DIV_RST  = 16'd12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_tune,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               phase_clr,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [MAG_W-1:0]   rom_data,
    output logic [OUT_W-1:0]   sample,
    output logic               sample_valid
);

    localparam int IDX_W = ADDR_W + 2;

    state_e             state_q;
    state_e             state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [PHASE_W-1:0] tune_q;
    logic [PHASE_W-1:0] tune_d;
    logic [1:0]         quad_q;
    logic [1:0]         quad_d;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic [OUT_W-1:0]   sample_q;
    logic [OUT_W-1:0]   sample_d;
    logic               sample_valid_q;
    logic               sample_valid_d;

    logic               tick;
    logic               accept;
    logic               fetch_go;
    logic [PHASE_W-1:0] phase_base;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         idx_quad;
    logic               idx_mirror;
    logic [ADDR_W-1:0]  table_addr;

    assign cfg_ready    = (state_q == ST_IDLE);
    assign accept       = cfg_valid && cfg_ready;
    assign fetch_go     = tick && (state_q == ST_IDLE);

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

    sine_prescaler #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .accept_i  (accept),
        .cfg_div_i (cfg_div),
        .tick_o    (tick)
    );

    // A clear coincident with a tick wins: the fetch sees phase zero
    assign phase_base = phase_clr ? '0 : phase_q;
    assign idx        = phase_base[PHASE_W-1 -: IDX_W];
    assign idx_quad   = idx[IDX_W-1 -: 2];
    assign idx_mirror = quad_mirrors(idx_quad);

    // Mirroring (2^ADDR_W-1)-a is a bitwise inversion of the in-quadrant offset
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_mirror
            assign table_addr[gi] = idx[gi] ^ idx_mirror;
        end
    endgenerate

    // Next-state and datapath: IDLE waits for a tick, FETCH covers ROM latency,
    // CAPTURE unfolds the magnitude around mid-scale
    always_comb begin
        state_d        = state_q;
        quad_d         = quad_q;
        rom_addr_d     = rom_addr_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        tune_d         = tune_q;
        phase_d        = phase_base;

        if (accept) begin
            tune_d = cfg_tune;
        end

        // The tick uses the tune value in force before any same-cycle accept
        if (fetch_go) begin
            phase_d = phase_base + tune_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fetch_go) begin
                    state_d    = ST_FETCH;
                    quad_d     = idx_quad;
                    rom_addr_d = table_addr;
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d        = ST_IDLE;
                sample_valid_d = 1'b1;
                if (quad_negative(quad_q)) begin
                    sample_d = OUT_W'({1'b0, ~rom_data});
                end else begin
                    sample_d = OUT_W'({1'b1, rom_data});
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            tune_q         <= TUNE_RST;
            quad_q         <= QUAD_0;
            rom_addr_q     <= '0;
            sample_q       <= OUT_W'(MIDSCALE);
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            tune_q         <= tune_d;
            quad_q         <= quad_d;
            rom_addr_q     <= rom_addr_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

endmodule

// File: tb/tb_sine_sequencer.sv
// Scoreboard bench for sine_sequencer: each scheduled tick pushes the expected
// sample and strobe cycle; a monitor pops and compares on every strobe.
module tb_sine_sequencer;

    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_tune;
    logic [15:0] cfg_div;
    logic        phase_clr;
    logic [6:0]  rom_addr;
    logic [8:0]  rom_data = 9'd0;
    logic [9:0]  sample;
    logic        sample_valid;

    always #(CLK_P/2) clk = ~clk;

    sine_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_tune     (cfg_tune),
        .cfg_div      (cfg_div),
        .phase_clr    (phase_clr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    // Synchronous ROM model: magnitude = 4 * address, one cycle read latency
    always @(posedge clk) rom_data <= {rom_addr, 2'b00};

    // Cycle counter: value seen at a negedge is the index of that cycle
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int smp;
        int cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tb_tune;
    logic [15:0] ph;
    int          tb_d;
    int          t_next;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected DAC code for a 9-bit table index
    function automatic int sample_of(input int idx);
        int quad;
        int a;
        int addr;
        int mag;
        quad = (idx >> 7) & 3;
        a    = idx & 127;
        addr = (quad % 2 == 1) ? (127 - a) : a;
        mag  = 4 * addr;
        return (quad < 2) ? (512 + mag) : (511 - mag);
    endfunction

    function automatic int clamp_div(input int d);
        return (d < 3) ? 3 : d;
    endfunction

    task automatic sb_push(input int idx, input int t_tick);
        exp_t e;
        e.smp = sample_of(idx);
        e.cyc = t_tick + 3;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Idle the sequencer, load tune/div with a phase clear, then enable
    task automatic start_run(input logic [15:0] tune, input logic [15:0] div);
        en = 1'b0;
        repeat (4) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_tune  = tune;
        cfg_div   = div;
        phase_clr = 1'b1;
        check_val("cfg_ready_start", int'(cfg_ready), 1);
        tb_tune = tune;
        tb_d    = clamp_div(int'(div));
        ph      = 16'h0000;
        t_next  = cyc + tb_d;
        @(negedge clk);
        cfg_valid = 1'b0;
        phase_clr = 1'b0;
        en        = 1'b1;
    endtask

    // Run n ticks; optionally clear phase or reconfigure on a given tick,
    // then drop en during the last fetch and check everything drained
    task automatic run_ticks(input int n, input int clr_k, input int cfg_k,
                             input logic [15:0] ntune, input logic [15:0] ndiv);
        for (int k = 1; k <= n; k++) begin
            int t;
            int idx;
            t   = t_next;
            idx = (k == clr_k) ? 0 : int'(ph[15:7]);
            sb_push(idx, t);
            ph = ((k == clr_k) ? 16'h0000 : ph) + tb_tune;
            wait_until(t);
            if (k == clr_k) phase_clr = 1'b1;
            if (k == cfg_k) begin
                cfg_valid = 1'b1;
                cfg_tune  = ntune;
                cfg_div   = ndiv;
                check_val("cfg_ready_tick", int'(cfg_ready), 1);
                tb_tune = ntune;
                tb_d    = clamp_div(int'(ndiv));
            end
            @(negedge clk);
            phase_clr = 1'b0;
            cfg_valid = 1'b0;
            t_next    = t + tb_d;
        end
        en = 1'b0;
        repeat (8) @(negedge clk);
        check_val("drain_empty", sb_q.size(), 0);
    endtask

    // Strobe monitor
    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_strobe", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("[TB] strobe cyc=%0d sample=%0d exp=%0d", cyc, sample, e.smp);
                    check_val("sample", int'(sample), e.smp);
                    check_val("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #(CLK_P * 20000);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_tune  = 16'h0000;
        cfg_div   = 16'h0000;
        phase_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_sample", int'(sample), 512);
        check_val("rst_valid", int'(sample_valid), 0);
        check_val("rst_ready", int'(cfg_ready), 1);
        check_val("rst_addr", int'(rom_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full-period unfold, indices 0..384 at div 4
        start_run(16'h0080, 16'd4);
        run_ticks(385, -1, -1, 16'h0, 16'h0);

        // Divisor clamp: 1 and 0 both run at period 3
        start_run(16'h0080, 16'd1);
        run_ticks(10, -1, -1, 16'h0, 16'h0);
        start_run(16'h0100, 16'd0);
        run_ticks(4, -1, -1, 16'h0, 16'h0);

        // Phase wrap going backwards
        start_run(16'hFF80, 16'd4);
        run_ticks(3, -1, -1, 16'h0, 16'h0);

        // Phase clear on the tick at index 200
        start_run(16'h0080, 16'd4);
        run_ticks(203, 201, -1, 16'h0, 16'h0);

        // Config accepted on a tick: old tune applied, new div from restart
        start_run(16'h0080, 16'd5);
        run_ticks(4, -1, 2, 16'h0200, 16'd6);

        // Reset during CAPTURE of the third tick
        start_run(16'h2000, 16'd4);
        t1 = t_next;
        sb_push(0, t1);
        sb_push(64, t1 + 4);
        wait_until(t1 + 9);
        en = 1'b0;
        wait_until(t1 + 10);
        check_val("busy_capture", int'(cfg_ready), 0);
        check_val("addr_capture", int'(rom_addr), 127);
        rst = 1'b1;
        #1;
        check_val("arst_sample", int'(sample), 512);
        check_val("arst_valid", int'(sample_valid), 0);
        check_val("arst_ready", int'(cfg_ready), 1);
        check_val("arst_addr", int'(rom_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("arst_drain", sb_q.size(), 0);

        // Reset defaults: tune 0x0080, div 12, phase 0
        en      = 1'b1;
        ph      = 16'h0000;
        tb_tune = 16'h0080;
        tb_d    = 12;
        t_next  = cyc + 11;
        run_ticks(2, -1, -1, 16'h0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
